// File: rtl/lapido_pkg.sv
// Shared encodings for the Lapido phase sequencer: phase states, opcode
// fields and the instruction class enumeration.
package lapido_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    TRAP      = 3'd6
  } phaseState;

  // instruction[31:29]
  localparam logic [2:0] CODE_ALU    = 3'b001;
  localparam logic [2:0] CODE_MEM    = 3'b100;
  localparam logic [2:0] CODE_LIT    = 3'b010;
  localparam logic [2:0] CODE_NOP    = 3'b000;
  localparam logic [2:0] CODE_BRANCH = 3'b101;

  // instruction[28:26] for branches, instruction[25:24] for LOADLIT
  localparam logic [2:0] SUB_BEQ     = 3'b001;
  localparam logic [2:0] SUB_BNE     = 3'b010;
  localparam logic [1:0] SUB_LOADLIT = 2'b10;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_ALU     = 3'd1,
    CLS_MEM     = 3'd2,
    CLS_LOADLIT = 3'd3,
    CLS_BEQ     = 3'd4,
    CLS_BNE     = 3'd5,
    CLS_UNKNOWN = 3'd6
  } opClass;

endpackage

// File: rtl/phase_sequencer_opclass_decode.sv
// Combinational classifier: top opcode byte (instruction[31:24]) to an
// instruction class plus the load/store selector for memory operations.
module opclass_decode
  import lapido_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [2:0] classCode,
  output logic       isStore
);

  opClass decodedClass;

  always_comb begin
    decodedClass = CLS_UNKNOWN;
    case (opcode[7:5])
      CODE_NOP: decodedClass = CLS_NOP;
      CODE_ALU: decodedClass = CLS_ALU;
      CODE_MEM: decodedClass = CLS_MEM;
      CODE_LIT: begin
        if (opcode[1:0] == SUB_LOADLIT) decodedClass = CLS_LOADLIT;
      end
      CODE_BRANCH: begin
        if (opcode[4:2] == SUB_BEQ)      decodedClass = CLS_BEQ;
        else if (opcode[4:2] == SUB_BNE) decodedClass = CLS_BNE;
      end
      default: decodedClass = CLS_UNKNOWN;
    endcase
  end

  assign classCode = decodedClass;
  assign isStore   = (opcode[7:5] == CODE_MEM) && opcode[0];

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with a shared
// memory-ready handshake, wait timeout into a sticky TRAP, and retire counter.
module phase_sequencer
  import lapido_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic [31:0]         instruction,
  input  logic                mem_ready,
  input  logic                branch_cond,
  output logic                imem_read_n,
  output logic                dmem_read_n,
  output logic                dmem_write_n,
  output logic                ir_load,
  output logic                decode_strobe,
  output logic                reg_write,
  output logic                pc_enable,
  output logic                pc_select,
  output logic                trap,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  // Last allowed wait: one more cycle without ready would be the MEM_TIMEOUT-th miss.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  phaseState           stateReg, stateNext;
  logic [WAIT_W-1:0]   waitReg, waitNext;
  opClass              classReg, classNext;
  logic                storeReg, storeNext;
  logic [RETIRE_W-1:0] retiredReg;

  logic [2:0] decodedBits;
  logic       decodedStore;
  opClass     decodedClass;
  logic       unusedInstrBits;

  opclass_decode opclassDecode (
    .opcode    (instruction[31:24]),
    .classCode (decodedBits),
    .isStore   (decodedStore)
  );

  assign decodedClass    = opClass'(decodedBits);
  assign unusedInstrBits = ^instruction[23:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      stateReg   <= IDLE;
      waitReg    <= '0;
      classReg   <= CLS_NOP;
      storeReg   <= 1'b0;
      retiredReg <= '0;
    end else begin
      stateReg <= stateNext;
      waitReg  <= waitNext;
      classReg <= classNext;
      storeReg <= storeNext;
      if (pc_enable) retiredReg <= retiredReg + RETIRE_W'(1);
    end
  end

  always_comb begin
    stateNext     = stateReg;
    waitNext      = '0;
    classNext     = classReg;
    storeNext     = storeReg;
    imem_read_n   = 1'b1;
    dmem_read_n   = 1'b1;
    dmem_write_n  = 1'b1;
    ir_load       = 1'b0;
    decode_strobe = 1'b0;
    reg_write     = 1'b0;
    pc_enable     = 1'b0;
    pc_select     = 1'b0;
    trap          = 1'b0;

    case (stateReg)
      IDLE: begin
        if (run) stateNext = FETCH;
      end
      FETCH: begin
        imem_read_n = 1'b0;
        if (mem_ready) begin
          ir_load   = 1'b1;
          stateNext = DECODE;
        end else if (waitReg == WAIT_LAST) begin
          stateNext = TRAP;
        end else begin
          waitNext = waitReg + WAIT_W'(1);
        end
      end
      DECODE: begin
        decode_strobe = 1'b1;
        classNext     = decodedClass;
        storeNext     = decodedStore;
        case (decodedClass)
          CLS_UNKNOWN: stateNext = TRAP;
          CLS_NOP: begin
            pc_enable = 1'b1;
            stateNext = FETCH;
          end
          default: stateNext = EXECUTE;
        endcase
      end
      EXECUTE: begin
        case (classReg)
          CLS_BEQ, CLS_BNE: begin
            pc_enable = 1'b1;
            pc_select = (classReg == CLS_BEQ) ? branch_cond : !branch_cond;
            stateNext = FETCH;
          end
          CLS_MEM:              stateNext = MEMORY;
          CLS_ALU, CLS_LOADLIT: stateNext = WRITEBACK;
          default:              stateNext = TRAP;
        endcase
      end
      MEMORY: begin
        if (storeReg) dmem_write_n = 1'b0;
        else          dmem_read_n  = 1'b0;
        if (mem_ready) begin
          if (storeReg) begin
            pc_enable = 1'b1;
            stateNext = FETCH;
          end else begin
            stateNext = WRITEBACK;
          end
        end else if (waitReg == WAIT_LAST) begin
          stateNext = TRAP;
        end else begin
          waitNext = waitReg + WAIT_W'(1);
        end
      end
      WRITEBACK: begin
        reg_write = 1'b1;
        pc_enable = 1'b1;
        stateNext = FETCH;
      end
      TRAP: begin
        trap = 1'b1;
      end
      default: stateNext = TRAP;
    endcase
  end

  assign state   = stateReg;
  assign retired = retiredReg;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench: table of instructions with expected timing/strobes via
// a scoreboard queue, plus hand sequences for trap, timeout, abort and wrap.
module tb_phase_sequencer;

  logic        clock = 1'b0;
  logic        reset, run, mem_ready, branch_cond;
  logic [31:0] instruction;

  logic        imem_read_n, dmem_read_n, dmem_write_n, ir_load, decode_strobe;
  logic        reg_write, pc_enable, pc_select, trap;
  logic [2:0]  state;
  logic [15:0] retired;

  logic        sImemN, sDmemRdN, sDmemWrN, sIrLoad, sDecode, sRegWrite;
  logic        sPcEnable, sPcSelect, sTrap;
  logic [2:0]  sState;
  logic [3:0]  smallRetired;

  int errors = 0;
  int checks = 0;
  int expRetired = 0;

  always #5 clock = ~clock;

  phase_sequencer #(.MEM_TIMEOUT(15), .RETIRE_W(16)) dut (
    .clock(clock), .reset(reset), .run(run), .instruction(instruction),
    .mem_ready(mem_ready), .branch_cond(branch_cond),
    .imem_read_n(imem_read_n), .dmem_read_n(dmem_read_n), .dmem_write_n(dmem_write_n),
    .ir_load(ir_load), .decode_strobe(decode_strobe), .reg_write(reg_write),
    .pc_enable(pc_enable), .pc_select(pc_select), .trap(trap),
    .state(state), .retired(retired)
  );

  // Narrow retire counter so wrap-around is reachable in a short run.
  phase_sequencer #(.MEM_TIMEOUT(15), .RETIRE_W(4)) smallDut (
    .clock(clock), .reset(reset), .run(run), .instruction(instruction),
    .mem_ready(mem_ready), .branch_cond(branch_cond),
    .imem_read_n(sImemN), .dmem_read_n(sDmemRdN), .dmem_write_n(sDmemWrN),
    .ir_load(sIrLoad), .decode_strobe(sDecode), .reg_write(sRegWrite),
    .pc_enable(sPcEnable), .pc_select(sPcSelect), .trap(sTrap),
    .state(sState), .retired(smallRetired)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        cond;
    int          iw;
    int          dw;
    int          lat;
    int          rw;
    logic        sel;
    int          dRd;
    int          dWr;
  } vecT;

  vecT sbQueue[$];
  vecT vecs[13];

  function automatic vecT mk(input string nm, input logic [31:0] ins, input logic c,
                             input int iw, input int dw, input int lat, input int rw,
                             input logic sel, input int dRd, input int dWr);
    vecT v;
    v.name = nm; v.instr = ins; v.cond = c; v.iw = iw; v.dw = dw; v.lat = lat;
    v.rw = rw; v.sel = sel; v.dRd = dRd; v.dWr = dWr;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rdy);
    @(posedge clock); #1;
    mem_ready = rdy;
    @(negedge clock);
  endtask

  task automatic resetDut();
    @(posedge clock); #1;
    reset = 1'b0; run = 1'b0; mem_ready = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_state", state, 0);
    check("rst_imem_n", imem_read_n, 1);
    check("rst_dmemrd_n", dmem_read_n, 1);
    check("rst_dmemwr_n", dmem_write_n, 1);
    check("rst_retired", retired, 0);
    check("rst_trap", trap, 0);
    check("rst_pc_enable", pc_enable, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    expRetired = 0;
  endtask

  task automatic startRun();
    @(posedge clock); #1;
    run = 1'b1; mem_ready = 1'b0;
    @(negedge clock);
    check("idle_before_run", state, 0);
  endtask

  task automatic runInstr(input vecT v);
    int cyc = 0;
    int rw = 0, dRd = 0, dWr = 0, im = 0, ds = 0;
    logic sel = 1'b0;
    bit done = 0;
    vecT e;
    sbQueue.push_back(v);
    while (!done && cyc < 60) begin
      cyc++;
      @(posedge clock); #1;
      instruction = v.instr;
      branch_cond = v.cond;
      run         = 1'b0;
      mem_ready   = (cyc == v.iw + 1) || (cyc == v.iw + 4 + v.dw);
      @(negedge clock);
      if (cyc == 1) begin
        check({v.name, "_start_state"}, state, 1);
        check({v.name, "_start_retired"}, retired, 32'(expRetired % 65536));
        check({v.name, "_start_small_retired"}, smallRetired, 32'(expRetired % 16));
      end
      if (!imem_read_n)  im++;
      if (!dmem_read_n)  dRd++;
      if (!dmem_write_n) dWr++;
      if (reg_write)     rw++;
      if (decode_strobe) ds++;
      if (pc_enable) begin
        done = 1;
        sel  = pc_select;
      end
    end
    e = sbQueue.pop_front();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no pc_enable within %0d cycles, required %0d", e.name, cyc, e.lat);
    end else begin
      check({e.name, "_latency"}, cyc, e.lat);
      check({e.name, "_reg_write"}, rw, e.rw);
      check({e.name, "_pc_select"}, sel, e.sel);
      check({e.name, "_dmem_read"}, dRd, e.dRd);
      check({e.name, "_dmem_write"}, dWr, e.dWr);
      check({e.name, "_imem_read"}, im, e.iw + 1);
      check({e.name, "_decode_strobe"}, ds, 1);
      expRetired++;
    end
    $display("txn %s instr=%08h latency=%0d retired_expected=%0d", e.name, e.instr, cyc, expRetired);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vecT nopV;
    logic [31:0] badWords[4];

    reset = 1'b0; run = 1'b0; mem_ready = 1'b0; branch_cond = 1'b0; instruction = 32'h0;

    vecs[0]  = mk("alu",     32'h20000000, 1'b0, 0,  0, 4,  1, 1'b0, 0, 0);
    vecs[1]  = mk("loadlit", 32'h42000000, 1'b0, 1,  0, 5,  1, 1'b0, 0, 0);
    vecs[2]  = mk("load3",   32'h80000000, 1'b0, 0,  3, 8,  1, 1'b0, 4, 0);
    vecs[3]  = mk("store2",  32'h81000000, 1'b0, 0,  2, 6,  0, 1'b0, 0, 3);
    vecs[4]  = mk("beq_t",   32'hA4000000, 1'b1, 0,  0, 3,  0, 1'b1, 0, 0);
    vecs[5]  = mk("bne_nt",  32'hA8000000, 1'b1, 0,  0, 3,  0, 1'b0, 0, 0);
    vecs[6]  = mk("beq_nt",  32'hA4000000, 1'b0, 0,  0, 3,  0, 1'b0, 0, 0);
    vecs[7]  = mk("bne_t",   32'hA8000000, 1'b0, 0,  0, 3,  0, 1'b1, 0, 0);
    vecs[8]  = mk("nop",     32'h00000000, 1'b0, 0,  0, 2,  0, 1'b0, 0, 0);
    vecs[9]  = mk("nop_w14", 32'h00000000, 1'b0, 14, 0, 16, 0, 1'b0, 0, 0);
    vecs[10] = mk("alu_x",   32'h3FFFFFFF, 1'b0, 0,  0, 4,  1, 1'b0, 0, 0);
    vecs[11] = mk("store_w", 32'h81FFFFFF, 1'b0, 1,  0, 5,  0, 1'b0, 0, 1);
    vecs[12] = mk("load_w",  32'h80FFFFFF, 1'b0, 2,  0, 7,  1, 1'b0, 1, 0);
    nopV = vecs[8];

    badWords[0] = 32'hE0000000;
    badWords[1] = 32'h41000000;
    badWords[2] = 32'hB0000000;
    badWords[3] = 32'h60000000;

    // Reset, idle without run, then the instruction table.
    resetDut();
    drive(1'b0);
    check("idle_hold_state", state, 0);
    drive(1'b1);
    check("idle_hold_imem_n", imem_read_n, 1);
    startRun();
    for (int i = 0; i < 13; i++) runInstr(vecs[i]);

    // Unknown classes trap straight from DECODE without retiring.
    foreach (badWords[k]) begin
      resetDut();
      startRun();
      runInstr(nopV);
      @(posedge clock); #1;
      instruction = badWords[k]; mem_ready = 1'b1;
      @(negedge clock);
      check("bad_ir_load", ir_load, 1);
      drive(1'b0);
      check("bad_decode_strobe", decode_strobe, 1);
      check("bad_decode_pc_enable", pc_enable, 0);
      drive(1'b1);
      check("bad_trap_state", state, 6);
      check("bad_trap_flag", trap, 1);
      for (int j = 0; j < 3; j++) begin
        @(posedge clock); #1;
        run = 1'b1; mem_ready = 1'b1;
        @(negedge clock);
        check("bad_trap_sticky", trap, 1);
        check("bad_trap_imem_n", imem_read_n, 1);
        check("bad_trap_retired", retired, 1);
      end
      $display("txn unknown instr=%08h trap=%0b", badWords[k], trap);
    end

    // FETCH timeout: 15 unanswered cycles, then TRAP until reset.
    resetDut();
    startRun();
    for (int c = 1; c <= 15; c++) begin
      drive(1'b0);
      check("timeout_wait_state", state, 1);
    end
    drive(1'b0);
    check("timeout_trap_state", state, 6);
    check("timeout_trap_flag", trap, 1);
    check("timeout_imem_n", imem_read_n, 1);
    drive(1'b1);
    check("timeout_trap_sticky", trap, 1);
    $display("txn fetch_timeout trap=%0b", trap);
    resetDut();

    // Reset during MEMORY of a store aborts with no PC update.
    startRun();
    runInstr(nopV);
    @(posedge clock); #1;
    instruction = 32'h81000000; mem_ready = 1'b1;
    @(negedge clock);
    drive(1'b0);
    drive(1'b0);
    drive(1'b0);
    check("abort_mem_state", state, 4);
    check("abort_mem_write_n", dmem_write_n, 0);
    @(posedge clock); #1;
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clock);
    check("abort_no_pc_enable", pc_enable, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("abort_idle_state", state, 0);
    check("abort_retired", retired, 0);
    check("abort_write_n", dmem_write_n, 1);
    $display("txn abort_store state=%0d", state);
    @(posedge clock); #1;
    reset = 1'b1;
    expRetired = 0;

    // Retire counter wrap on the narrow instance.
    startRun();
    for (int n = 0; n < 15; n++) runInstr(nopV);
    drive(1'b0);
    check("wrap_small_max", smallRetired, 15);
    check("wrap_main_15", retired, 15);
    runInstr(nopV);
    drive(1'b0);
    check("wrap_small_zero", smallRetired, 0);
    check("wrap_main_16", retired, 16);
    $display("txn retire_wrap small=%0d main=%0d", smallRetired, retired);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Multi-cycle phase sequencer for the Lapido processor. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and waits on a shared memory ready handshake at each memory phase. It drives the PC, instruction register and memory strobes, strobes the instruction decoder once per instruction, and gates register writeback. Memory strobes are active-low, matching the datapath (1 = inactive).

Parameters:
MEM_TIMEOUT, 15, maximum wait cycles on mem_ready before entering TRAP (must be ≥1)
RETIRE_W, 16, width of the retired-instruction counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous reset, active-low
run  in  1  leave IDLE and start fetching
instruction  in  32  fetched word (instruction-memory data bus)
mem_ready  in  1  memory access complete this cycle (shared by instruction and data memory)
branch_cond  in  1  datapath equality flag (1 = operands equal)
imem_read_n  out  1  instruction memory read, active-low
dmem_read_n  out  1  data memory read, active-low
dmem_write_n  out  1  data memory write, active-low
ir_load  out  1  capture instruction into IR
decode_strobe  out  1  one-cycle enable to the instruction decoder
reg_write  out  1  register file write enable
pc_enable  out  1  PC update pulse
pc_select  out  1  0 = PC+1, 1 = branch target
trap  out  1  sticky fault flag
state  out  3  current state (debug)
retired  out  RETIRE_W  count of completed instructions, wraps

Behaviour:
- Reset: if reset==0 at a posedge, the block goes to IDLE. All registers clear: retired=0, wait counter=0, latched class=NOP. Outputs in IDLE: all _n strobes=1; ir_load, decode_strobe, reg_write, pc_enable, pc_select and trap all =0. Reset mid-operation aborts the instruction with no PC update or writeback.
- Instruction classes come from instruction[31:29]:
  - 001 = ALU
  - 100 = MEM; bit24 = 0 is load, bit24 = 1 is store
  - 010 with [25:24]=10 = LOADLIT
  - 000 = NOP
  - 101 with [28:26]=001 = BEQ; with [28:26]=010 = BNE
  - anything else = UNKNOWN
- The class is latched at the end of DECODE.
- Outputs are decoded from state and latched class. ir_load, pc_enable and pc_select also depend on mem_ready and branch_cond in the same cycle.
- IDLE: if run=1, go to FETCH; otherwise stay.
- FETCH:
  - imem_read_n=0. The wait counter increments each cycle mem_ready=0.
  - mem_ready=1: ir_load=1, go to DECODE, counter clears.
  - Counter reaches MEM_TIMEOUT with mem_ready=0: go to TRAP.
  - mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT: ready wins.
- DECODE: decode_strobe=1 for exactly one cycle, then:
  - UNKNOWN: go to TRAP.
  - NOP: pc_enable=1, go to FETCH.
  - Otherwise: go to EXECUTE.
- EXECUTE:
  - BEQ/BNE: pc_enable=1; pc_select=1 if taken (BEQ with branch_cond=1, or BNE with branch_cond=0), else 0; go to FETCH.
  - ALU/LOADLIT: go to WRITEBACK.
  - MEM: go to MEMORY.
- MEMORY:
  - Load asserts dmem_read_n=0; store asserts dmem_write_n=0. Same wait/timeout rules as FETCH.
  - On mem_ready=1: store does pc_enable=1 and goes to FETCH; load goes to WRITEBACK.
- WRITEBACK: reg_write=1, pc_enable=1, go to FETCH.
- TRAP: trap=1, all strobes inactive. Stays in TRAP until reset.
- retired increments on every pc_enable cycle and wraps from 2^RETIRE_W−1 to 0.
- run is sampled only in IDLE; deasserting run mid-program has no effect.
- Latency with zero-wait memory (cycles from entering FETCH to pc_enable, inclusive): NOP 2, branch 3, ALU/LOADLIT 4, store 4, load 5. Each memory wait cycle adds 1.

Decomposition:
- Package lapido_pkg holds:
  - state encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, TRAP=6
  - class codes for [31:29]: 001, 100, 010, 000, 101
  - branch subcodes for [28:26]: 001, 010
  - LOADLIT subcode for [25:24]: 10
  - class enum
- Sub-module opclass_decode: combinational, instruction[31:24] → class enum plus load/store bit.

Test Plan:
- Reset/idle: reset=0 for 2 cycles, then run=0 → state=0, all _n=1, retired=0. Then run=1 → state=1 next cycle with imem_read_n=0.
- ALU with immediate ready: instruction=0x20000000, mem_ready=1 → ir_load at cycle 1, decode_strobe at 2, reg_write+pc_enable at 4, retired=1.
- Load with 3 data wait cycles: instruction=0x80000000 → dmem_read_n=0 for 4 cycles, then reg_write at WRITEBACK. Total 8 cycles to pc_enable.
- Branches:
  - 0xA4000000 with branch_cond=1 → pc_select=1, pc_enable=1 in EXECUTE.
  - 0xA8000000 with branch_cond=1 → pc_select=0.
  - NOP 0x00000000 → pc_enable at cycle 2.
- Timeout and unknown:
  - mem_ready held 0 in FETCH → TRAP after 15 wait cycles; trap stays 1 until reset.
  - 0xE0000000 → TRAP directly from DECODE; retired unchanged.
- Abort and wrap:
  - reset=0 during MEMORY of store 0x81000000 → IDLE next cycle, no pc_enable.
  - Preload retired=0xFFFF, retire one instruction → retired=0.
